// File: rtl/intctl.sv
// intctl -- interrupt request arbiter and acknowledge sequencer.
//
// Purpose:
//   Prioritises level-sensitive device requests (highest index wins) and
//   raises INTREQ towards the microcode sequencer while the PSW IE bit is set.
//   On TAKEN it issues a one-cycle IACK to the winner and an IECLR pulse to the
//   PSW. It then waits in VEC until RE gates the vector (VBASE + 4*n) onto Q.
//
// Optional feature (compile-time macro INTCTL_MASK_EN):
//   When defined, a NIRQ-bit mask register (reset all-ones) is written from D
//   on WE. It can be read onto Q with MRE. When undefined, every request is
//   enabled, and D, WE and MRE are ignored.
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   IRQ        in   NIRQ level-sensitive requests, bit n = device n
//   IE         in   PSW interrupt-enable bit
//   TAKEN      in   sequencer accepts the pending interrupt (one-cycle pulse)
//   RE         in   gate vector onto Q in VEC; also consumes the vector
//   D          in   16-bit data bus (mask write data)
//   WE         in   mask write strobe
//   MRE        in   gate mask onto Q
//   INTREQ     out  registered: masked request pending and IE set
//   IACK       out  one-hot acknowledge to the winning device, one cycle
//   IECLR      out  registered one-cycle pulse clearing PSW IE
//   Q          out  vector / mask / zero (combinational)
//   PEND       out  OR of masked requests, independent of IE
//   DBG_STATE  out  FSM state: 0 = IDLE, 1 = ACK, 2 = VEC
//
// Handshake: TAKEN is honoured only in IDLE while INTREQ is 1. The acknowledge
// cycle follows. The controller then holds the vector until a cycle with RE=1,
// and returns to IDLE on the next edge.

module intctl #(
  parameter int          NIRQ  = 8,
  parameter logic [15:0] VBASE = 16'o000100
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [NIRQ-1:0] IRQ,
  input  logic            IE,
  input  logic            TAKEN,
  input  logic            RE,
  input  logic [15:0]     D,
  input  logic            WE,
  input  logic            MRE,
  output logic            INTREQ,
  output logic [NIRQ-1:0] IACK,
  output logic            IECLR,
  output logic [15:0]     Q,
  output logic            PEND,
  output logic [1:0]      DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_VEC  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            intreq_q, intreq_d;
  logic [3:0]      win_q, win_d;
  logic [NIRQ-1:0] iack_q, iack_d;
  logic            ieclr_q, ieclr_d;

  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] masked;
  logic [3:0]      enc;
  logic [NIRQ-1:0] win_onehot;
  logic [15:0]     mask_ext;

  // D is only partly consumed (or not at all) depending on NIRQ and build.
  logic unused_inputs;
  assign unused_inputs = ^{D, WE, MRE};

`ifdef INTCTL_MASK_EN
  logic [NIRQ-1:0] mask_q;

  // Mask write lands at the edge, so arbitration in the write cycle still
  // sees the old mask.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mask_q <= '1;
    end else if (WE) begin
      mask_q <= D[NIRQ-1:0];
    end
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  assign masked = IRQ & mask;
  assign PEND   = |masked;

  // Highest set index wins: later loop iterations override earlier ones.
  always_comb begin
    enc = 4'd0;
    for (int i = 0; i < NIRQ; i++) begin
      if (masked[i]) enc = 4'(i);
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NIRQ; i++) begin
      win_onehot[i] = (win_q == 4'(i));
    end
  end

  always_comb begin
    mask_ext = 16'd0;
    mask_ext[NIRQ-1:0] = mask;
  end

  // Next-state logic. IACK/IECLR are computed on the IDLE->ACK transition so
  // that they come out of flops during the ACK cycle. WIN stops updating from
  // the TAKEN cycle, so a request dropped after TAKEN still gets its vector.
  always_comb begin
    state_d  = state_q;
    intreq_d = 1'b0;
    win_d    = win_q;
    iack_d   = '0;
    ieclr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TAKEN && intreq_q) begin
          state_d = S_ACK;
          iack_d  = win_onehot;
          ieclr_d = 1'b1;
        end else begin
          intreq_d = PEND & IE;
          win_d    = enc;
        end
      end
      S_ACK: begin
        state_d = S_VEC;
      end
      S_VEC: begin
        if (RE) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      intreq_q <= 1'b0;
      win_q    <= 4'd0;
      iack_q   <= '0;
      ieclr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      intreq_q <= intreq_d;
      win_q    <= win_d;
      iack_q   <= iack_d;
      ieclr_q  <= ieclr_d;
    end
  end

  // Read mux: the vector has priority over the mask read in VEC with RE.
  always_comb begin
    Q = 16'd0;
`ifdef INTCTL_MASK_EN
    if (MRE) Q = mask_ext;
`endif
    if (state_q == S_VEC && RE) Q = VBASE + {10'd0, win_q, 2'b00};
  end

  assign INTREQ    = intreq_q;
  assign IACK      = iack_q;
  assign IECLR     = ieclr_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_intctl.sv
// tb_intctl -- self-checking bench for intctl (NIRQ = 8).
// Directed vector table, a mask sequence when INTCTL_MASK_EN is defined, then
// randomized cycles compared against a transaction-level reference model.

module tb_intctl;

  localparam int          NIRQ  = 8;
  localparam logic [15:0] VBASE = 16'o000100;

  // ---------------- clock / reset ----------------
  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic            RESET;
  logic [NIRQ-1:0] IRQ;
  logic            IE, TAKEN, RE, WE, MRE;
  logic [15:0]     D;
  logic            INTREQ, IECLR, PEND;
  logic [NIRQ-1:0] IACK;
  logic [15:0]     Q;
  logic [1:0]      DBG_STATE;

  intctl #(.NIRQ(NIRQ), .VBASE(VBASE)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IRQ(IRQ), .IE(IE), .TAKEN(TAKEN),
    .RE(RE), .D(D), .WE(WE), .MRE(MRE), .INTREQ(INTREQ), .IACK(IACK),
    .IECLR(IECLR), .Q(Q), .PEND(PEND), .DBG_STATE(DBG_STATE)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic [7:0] irq, input logic ie, input logic taken,
                       input logic re, input logic rst);
    IRQ = irq; IE = ie; TAKEN = taken; RE = re; RESET = rst;
    WE = 1'b0; MRE = 1'b0; D = 16'h0000;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  irq;
    logic        ie, taken, re, rst;
    logic        intreq;
    logic [7:0]  iack;
    logic        ieclr;
    logic [15:0] q;
    logic        pend;
    logic [1:0]  st;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl[NV];

  function automatic vec_t mk(logic [7:0] irq, logic ie, logic taken, logic re, logic rst,
                              logic intreq, logic [7:0] iack, logic ieclr,
                              logic [15:0] q, logic pend, logic [1:0] st);
    vec_t v;
    v.irq = irq; v.ie = ie; v.taken = taken; v.re = re; v.rst = rst;
    v.intreq = intreq; v.iack = iack; v.ieclr = ieclr; v.q = q; v.pend = pend; v.st = st;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Transaction view: "req" = INTREQ level, "acking" = acknowledge cycle in
  // progress, "awaiting" = a vector is outstanding; exp_q holds vectors owed.
  bit           m_req, m_acking, m_awaiting;
  int           m_win;
  logic [7:0]   m_mask;
  logic [15:0]  exp_q[$];

  function automatic int highest(logic [7:0] m);
    int h = 0;
    for (int i = 0; i < NIRQ; i++) if (m[i]) h = i;
    return h;
  endfunction

  task automatic model_check();
    logic [7:0]  m;
    logic [15:0] eq;
    m  = IRQ & m_mask;
    eq = 16'h0000;
`ifdef INTCTL_MASK_EN
    if (MRE) eq = {8'h00, m_mask};
`endif
    if (m_awaiting && RE) eq = exp_q[0];
    chk("rnd_intreq", INTREQ, m_req);
    chk("rnd_iack", IACK, m_acking ? (8'h01 << m_win) : 8'h00);
    chk("rnd_ieclr", IECLR, m_acking);
    chk("rnd_pend", PEND, (m != 0));
    chk("rnd_q", Q, eq);
    chk("rnd_state", DBG_STATE, m_acking ? 2'd1 : (m_awaiting ? 2'd2 : 2'd0));
  endtask

  task automatic model_step();
    logic [7:0] m_old;
    if (RESET) begin
      m_req = 0; m_acking = 0; m_awaiting = 0; m_win = 0; m_mask = 8'hFF;
      exp_q.delete();
    end else begin
      m_old = IRQ & m_mask;
`ifdef INTCTL_MASK_EN
      if (WE) m_mask = D[7:0];
`endif
      if (m_acking) begin
        m_acking = 0;
        m_awaiting = 1;
      end else if (m_awaiting) begin
        if (RE) begin
          m_awaiting = 0;
          void'(exp_q.pop_front());
        end
      end else if (TAKEN && m_req) begin
        m_acking = 1;
        m_req = 0;
        exp_q.push_back(VBASE + 16'(4 * m_win));
      end else begin
        m_req = (m_old != 0) && IE;
        m_win = highest(m_old);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //                irq  ie tk re rs | irq  iack  ieclr q        pend st
    tbl[0]  = mk(8'hFF, 1, 0, 0, 1,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[1]  = mk(8'h04, 1, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[2]  = mk(8'h04, 1, 0, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[3]  = mk(8'h04, 1, 1, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[4]  = mk(8'h04, 0, 0, 0, 0,  0, 8'h04, 1, 16'h0000, 1, 1);
    tbl[5]  = mk(8'h04, 0, 0, 1, 0,  0, 8'h00, 0, 16'o000110, 1, 2);
    tbl[6]  = mk(8'h00, 0, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 0, 0);
    tbl[7]  = mk(8'h81, 1, 1, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[8]  = mk(8'h81, 1, 1, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[9]  = mk(8'h01, 0, 0, 0, 0,  0, 8'h80, 1, 16'h0000, 1, 1);
    tbl[10] = mk(8'h01, 0, 0, 1, 0,  0, 8'h00, 0, 16'o000134, 1, 2);
    tbl[11] = mk(8'h01, 1, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[12] = mk(8'h01, 1, 1, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[13] = mk(8'h00, 0, 0, 0, 0,  0, 8'h01, 1, 16'h0000, 0, 1);
    tbl[14] = mk(8'h00, 0, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 0, 2);
    tbl[15] = mk(8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 16'o000100, 0, 2);
    tbl[16] = mk(8'h10, 1, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[17] = mk(8'h10, 1, 1, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[18] = mk(8'h00, 0, 0, 0, 0,  0, 8'h10, 1, 16'h0000, 0, 1);
    tbl[19] = mk(8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 16'o000120, 0, 2);
    tbl[20] = mk(8'h02, 0, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[21] = mk(8'h02, 0, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[22] = mk(8'h02, 1, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[23] = mk(8'h02, 1, 1, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[24] = mk(8'h02, 0, 0, 0, 0,  0, 8'h02, 1, 16'h0000, 1, 1);
    tbl[25] = mk(8'h02, 0, 0, 0, 1,  0, 8'h00, 0, 16'h0000, 1, 2);
    tbl[26] = mk(8'h02, 1, 0, 1, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[27] = mk(8'h02, 1, 0, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[28] = mk(8'h02, 1, 1, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);
    tbl[29] = mk(8'h02, 1, 0, 0, 1,  0, 8'h02, 1, 16'h0000, 1, 1);
    tbl[30] = mk(8'h02, 1, 0, 0, 0,  0, 8'h00, 0, 16'h0000, 1, 0);
    tbl[31] = mk(8'h02, 1, 0, 0, 0,  1, 8'h00, 0, 16'h0000, 1, 0);

    // First reset cycle; the first table row is the second reset cycle.
    drive(8'hFF, 1, 0, 0, 1);
    next_cycle();

    for (int r = 0; r < NV; r++) begin
      drive(tbl[r].irq, tbl[r].ie, tbl[r].taken, tbl[r].re, tbl[r].rst);
      @(negedge CLOCK);
      chk($sformatf("row%0d_intreq", r), INTREQ, tbl[r].intreq);
      chk($sformatf("row%0d_iack", r), IACK, tbl[r].iack);
      chk($sformatf("row%0d_ieclr", r), IECLR, tbl[r].ieclr);
      chk($sformatf("row%0d_q", r), Q, tbl[r].q);
      chk($sformatf("row%0d_pend", r), PEND, tbl[r].pend);
      chk($sformatf("row%0d_state", r), DBG_STATE, tbl[r].st);
      next_cycle();
    end

`ifdef INTCTL_MASK_EN
    // Mask sequence: a write is visible from the next cycle only.
    drive(8'h00, 1, 0, 0, 1);
    next_cycle();
    drive(8'h00, 1, 0, 0, 0); WE = 1'b1; D = 16'h00FE;
    @(negedge CLOCK); chk("mask_c0_intreq", INTREQ, 1'b0);
    next_cycle();
    drive(8'h01, 1, 0, 0, 0); MRE = 1'b1;
    @(negedge CLOCK); chk("mask_c1_q", Q, 16'h00FE); chk("mask_c1_pend", PEND, 1'b0);
    next_cycle();
    drive(8'h01, 1, 0, 0, 0);
    @(negedge CLOCK); chk("mask_c2_intreq", INTREQ, 1'b0);
    next_cycle();
    drive(8'h01, 1, 0, 0, 0); WE = 1'b1; D = 16'h00FF;
    @(negedge CLOCK); chk("mask_c3_intreq", INTREQ, 1'b0); chk("mask_c3_pend", PEND, 1'b0);
    next_cycle();
    drive(8'h01, 1, 0, 0, 0);
    @(negedge CLOCK); chk("mask_c4_intreq", INTREQ, 1'b0); chk("mask_c4_pend", PEND, 1'b1);
    next_cycle();
    drive(8'h01, 1, 0, 0, 0);
    @(negedge CLOCK); chk("mask_c5_intreq", INTREQ, 1'b1);
    next_cycle();
`endif

    // Randomized cycles against the reference model; first cycle is a reset.
    for (int c = 0; c < 3000; c++) begin
      IRQ   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      IE    = ($urandom_range(0, 3) != 0);
      TAKEN = ($urandom_range(0, 2) == 0);
      RE    = ($urandom_range(0, 2) == 0);
      RESET = (c == 0) || ($urandom_range(0, 199) == 0);
      WE    = ($urandom_range(0, 15) == 0);
      D     = 16'($urandom_range(0, 65535));
      MRE   = ($urandom_range(0, 3) == 0);
      @(negedge CLOCK);
      if (c > 0) model_check();
      model_step();
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
